// File: rtl/bridge_pkg.sv
// Shared types and switch patterns for the H-bridge sequencer and command decoder.
//   mode_t      : requested / applied bridge mode
//   state_t     : sequencer state encoding (ST_*)
//   top_pat/bot_pat : per-mode high-side / low-side gate patterns, bit 0 = switch 1
package bridge_pkg;

    typedef enum logic [2:0] {
        PAUSE     = 3'd0,
        PLUS      = 3'd1,
        MINUS     = 3'd2,
        BALLAST_P = 3'd3,
        BALLAST_N = 3'd4
    } mode_t;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned SW_W    = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_STEADY = 2'd0;
    localparam state_t ST_DEAD   = 2'd1;
    localparam state_t ST_KILL   = 2'd2;

    // Highest legal mode code; anything above is a request error.
    localparam logic [MODE_W-1:0] MODE_MAX = 3'd4;

    // High-side pattern per mode.
    function automatic logic [SW_W-1:0] top_pat(input mode_t m);
        case (m)
            PLUS:      top_pat = 4'b0001;
            MINUS:     top_pat = 4'b0010;
            BALLAST_P: top_pat = 4'b0100;
            BALLAST_N: top_pat = 4'b1000;
            default:   top_pat = 4'b0000;
        endcase
    endfunction

    // Low-side pattern per mode.
    function automatic logic [SW_W-1:0] bot_pat(input mode_t m);
        case (m)
            PLUS:      bot_pat = 4'b0010;
            MINUS:     bot_pat = 4'b0001;
            BALLAST_P: bot_pat = 4'b1000;
            BALLAST_N: bot_pat = 4'b0100;
            default:   bot_pat = 4'b0000;
        endcase
    endfunction

    // Complete registered state of the sequencer.
    typedef struct packed {
        state_t               st;
        logic [TIMER_W-1:0]   timer;
        mode_t                target;
        mode_t                cur;
        logic [SW_W-1:0]      top;
        logic [SW_W-1:0]      bot;
        logic                 err;
    } seq_state_t;

endpackage

// File: rtl/bridge_sequencer.sv
// H-bridge mode sequencer: inserts DEADTIME all-off cycles before any switch
// turn-on, holds each mode for MIN_ON cycles, and forces all-off on kill.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req_valid/req_mode   : mode request, accepted with req_ready
//   req_ready            : request acceptance (decoded from state and kill)
//   req_err              : one-cycle pulse for an accepted illegal mode (5..7)
//   kill                 : fault input, forces all switches off
//   o_top/o_bot [4:1]    : registered high/low-side gate drives
//   cur_mode             : mode currently applied to the outputs
//   busy                 : high while in dead time
module bridge_sequencer
    import bridge_pkg::*;
#(
    parameter int unsigned DEADTIME = 50,
    parameter int unsigned MIN_ON   = 500
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [2:0]  req_mode,
    output logic        req_ready,
    output logic        req_err,
    input  logic        kill,
    output logic [4:1]  o_top,
    output logic [4:1]  o_bot,
    output logic [2:0]  cur_mode,
    output logic        busy
);

    localparam logic [TIMER_W-1:0] DEAD_LOAD = TIMER_W'(DEADTIME - 1);
    localparam logic [TIMER_W-1:0] ON_LOAD   = TIMER_W'(MIN_ON - 1);

    seq_state_t q;
    seq_state_t d;
    mode_t      rmode;
    logic       accept;

    assign rmode = mode_t'(req_mode);

    // Ready only when the hold time has expired, or from the kill state once kill drops.
    assign req_ready = !kill && (((q.st == ST_STEADY) && (q.timer == '0)) || (q.st == ST_KILL));
    assign accept    = req_valid && req_ready;

    // Next-state logic.
    always_comb begin
        d     = q;
        d.err = 1'b0;
        if ((q.st == ST_STEADY) && (q.timer != '0)) begin
            d.timer = q.timer - TIMER_W'(1);
        end

        if (kill) begin
            d.st     = ST_KILL;
            d.timer  = '0;
            d.cur    = PAUSE;
            d.target = PAUSE;
            d.top    = '0;
            d.bot    = '0;
        end else if (q.st == ST_DEAD) begin
            if (q.timer == '0) begin
                d.st    = ST_STEADY;
                d.cur   = q.target;
                d.top   = top_pat(q.target);
                d.bot   = bot_pat(q.target);
                d.timer = ON_LOAD;
            end else begin
                d.timer = q.timer - TIMER_W'(1);
            end
        end else if (accept) begin
            if (req_mode > MODE_MAX) begin
                d.err = 1'b1;
            end else if (rmode == PAUSE) begin
                d.st    = ST_STEADY;
                d.cur   = PAUSE;
                d.top   = '0;
                d.bot   = '0;
                d.timer = '0;
            end else if (rmode != q.cur) begin
                // From ST_KILL cur is PAUSE, so every non-PAUSE mode takes this path.
                d.st     = ST_DEAD;
                d.target = rmode;
                d.cur    = PAUSE;
                d.top    = '0;
                d.bot    = '0;
                d.timer  = DEAD_LOAD;
            end
        end
    end

    // State register; reset also drops any pending dead-time target.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '{st: ST_STEADY, timer: '0, target: PAUSE, cur: PAUSE,
                   top: '0, bot: '0, err: 1'b0};
        end else begin
            q <= d;
        end
    end

    assign o_top    = q.top;
    assign o_bot    = q.bot;
    assign cur_mode = q.cur;
    assign req_err  = q.err;
    assign busy     = (q.st == ST_DEAD);

endmodule
